// File: rtl/axis_uart_tx_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
interface axis_uart_tx_if;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter: FIFO-buffered bytes serialised as
// start / DATA_BITS (LSB first) / optional parity / STOP_BITS frames.
module axis_uart_tx #(
  parameter int unsigned CLK_FREQ   = 16000000,
  parameter int unsigned BAUD_RATE  = 57600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  axis_uart_tx_if.slave                 s_axis,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic                          o_pkt_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned EW  = DATA_BITS + 1;

  if (DIV < 2) begin : g_div_chk
    $error("axis_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
    $error("axis_uart_tx: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("axis_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("axis_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("axis_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam lvl_t       LVL_FULL = lvl_t'(FIFO_DEPTH);
  localparam cnt_t       DIV_M1   = cnt_t'(DIV - 1);
  localparam logic [3:0] DB_M1    = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_M1    = 4'(STOP_BITS - 1);

  // ---------------- FIFO ----------------
  logic [EW-1:0]        mem [FIFO_DEPTH];
  ptr_t                 wr_ptr;
  ptr_t                 rd_ptr;
  lvl_t                 level;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_last;
  logic                 tdata_unused;

  assign empty         = (level == '0);
  assign s_axis.tready = (level != LVL_FULL);
  assign push          = s_axis.tvalid & s_axis.tready;
  assign head_data     = mem[rd_ptr][DATA_BITS-1:0];
  assign head_last     = mem[rd_ptr][DATA_BITS];
  assign tdata_unused  = ^(s_axis.tdata >> DATA_BITS);
  assign o_fifo_level  = level;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata[DATA_BITS-1:0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   level <= level + lvl_t'(1);
        2'b01:   level <= level - lvl_t'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  state_t               state, state_n;
  cnt_t                 baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 frm_last, last_n;
  logic                 line_n;
  logic                 pkt_n;
  logic                 bit_end;

  assign bit_end = (baud_cnt == '0);

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? DIV_M1 : baud_cnt - cnt_t'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    last_n  = frm_last;
    line_n  = 1'b1;
    pkt_n   = 1'b0;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        baud_n = DIV_M1;
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        line_n = 1'b0;
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        line_n = shreg[0];
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == DB_M1) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        line_n = par_bit;
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == SB_M1) begin
            // back-to-back frames: pop on the last stop clock, no idle gap
            pkt_n   = frm_last;
            bit_n   = '0;
            pop     = !empty;
            state_n = empty ? S_IDLE : S_START;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (pop) begin
      shreg_n = head_data;
      par_n   = (PARITY == 1) ? ~(^head_data) : ^head_data;
      last_n  = head_last;
    end
  end

  // Line, busy and pkt_done are registered one clock behind the FSM so the
  // three stay aligned with the bit actually on the wire.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= DIV_M1;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      frm_last   <= 1'b0;
      o_uart_tx  <= 1'b1;
      o_pkt_done <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      par_bit    <= par_n;
      frm_last   <= last_n;
      o_uart_tx  <= line_n;
      o_pkt_done <= pkt_n;
      o_busy     <= (state != S_IDLE) || !empty;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Randomised bench for axis_uart_tx: three configurations checked every clock
// against a frame-schedule model of the serial line, FIFO and status outputs.
module tb_axis_uart_tx;

  localparam int ND   = 3;
  localparam int MAXF = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int   cyc      = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst_n;
  end

  int n_chk = 0;
  int n_bad = 0;
  int mode  = 2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // configuration table: 8N1 /4, 7O2 /3, 5E1 /5
  function automatic int cfg_div(int d);
    case (d) 0: return 4; 1: return 3; default: return 5; endcase
  endfunction
  function automatic int cfg_db(int d);
    case (d) 0: return 8; 1: return 7; default: return 5; endcase
  endfunction
  function automatic int cfg_par(int d);
    case (d) 0: return 0; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int cfg_sb(int d);
    case (d) 0: return 1; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int cfg_depth(int d);
    case (d) 0: return 4; 1: return 2; default: return 8; endcase
  endfunction
  function automatic int frame_len(int d);
    return (1 + cfg_db(d) + ((cfg_par(d) != 0) ? 1 : 0) + cfg_sb(d)) * cfg_div(d);
  endfunction

  // value of bit slot idx (0 = start) of a frame carrying data
  function automatic logic frame_bit(int d, logic [7:0] data, int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= cfg_db(d)) return data[idx-1];
    if (cfg_par(d) != 0 && idx == cfg_db(d) + 1) begin
      for (int j = 0; j < cfg_db(d); j++) ones += int'(data[j]);
      return (cfg_par(d) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  logic       tvalid_d [ND] = '{default: 1'b0};
  logic [7:0] tdata_d  [ND] = '{default: 8'h00};
  logic       tlast_d  [ND] = '{default: 1'b0};
  logic       line_s   [ND];
  logic       busy_s   [ND];
  logic       pkt_s    [ND];
  logic       tready_s [ND];
  int         lvl_s    [ND];

  axis_uart_tx_if bus0 ();
  axis_uart_tx_if bus1 ();
  axis_uart_tx_if bus2 ();

  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic [3:0] lvl2;

  assign bus0.tvalid = tvalid_d[0];
  assign bus0.tdata  = tdata_d[0];
  assign bus0.tlast  = tlast_d[0];
  assign bus1.tvalid = tvalid_d[1];
  assign bus1.tdata  = tdata_d[1];
  assign bus1.tlast  = tlast_d[1];
  assign bus2.tvalid = tvalid_d[2];
  assign bus2.tdata  = tdata_d[2];
  assign bus2.tlast  = tlast_d[2];
  assign tready_s[0] = bus0.tready;
  assign tready_s[1] = bus1.tready;
  assign tready_s[2] = bus2.tready;
  assign lvl_s[0]    = int'(lvl0);
  assign lvl_s[1]    = int'(lvl1);
  assign lvl_s[2]    = int'(lvl2);

  axis_uart_tx #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .s_axis(bus0), .o_uart_tx(line_s[0]),
    .o_busy(busy_s[0]), .o_pkt_done(pkt_s[0]), .o_fifo_level(lvl0));

  axis_uart_tx #(.CLK_FREQ(300), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .s_axis(bus1), .o_uart_tx(line_s[1]),
    .o_busy(busy_s[1]), .o_pkt_done(pkt_s[1]), .o_fifo_level(lvl1));

  axis_uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(200), .DATA_BITS(5), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .s_axis(bus2), .o_uart_tx(line_s[2]),
    .o_busy(busy_s[2]), .o_pkt_done(pkt_s[2]), .o_fifo_level(lvl2));

  // Model: frame k occupies the line over [s, s+L), s = max(accept+2, previous end);
  // it is popped from the FIFO at edge s-1.
  int         f_a    [ND][MAXF];
  int         f_s    [ND][MAXF];
  logic [7:0] f_dat  [ND][MAXF];
  logic       f_last [ND][MAXF];
  int         nf      [ND] = '{default: 0};
  int         exp_lvl [ND] = '{default: 0};

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        int   e, len, dv, lvl, s;
        logic el, eb, ep, acc;
        e   = cyc;
        len = frame_len(d);
        dv  = cfg_div(d);
        acc = 1'b0;
        if (!rst_n) begin
          nf[d]      = 0;
          exp_lvl[d] = 0;
          check($sformatf("d%0d rst line @%0d", d, e), line_s[d], 1);
          check($sformatf("d%0d rst level @%0d", d, e), lvl_s[d], 0);
          check($sformatf("d%0d rst tready @%0d", d, e), tready_s[d], 1);
          check($sformatf("d%0d rst busy @%0d", d, e), busy_s[d], 0);
          check($sformatf("d%0d rst pkt @%0d", d, e), pkt_s[d], 0);
        end else begin
          if (rst_edge && tvalid_d[d] && exp_lvl[d] != cfg_depth(d)) begin
            acc = 1'b1;
            s = e + 2;
            if (nf[d] > 0 && f_s[d][nf[d]-1] + len > s) s = f_s[d][nf[d]-1] + len;
            if (nf[d] < MAXF) begin
              f_a[d][nf[d]]    = e;
              f_s[d][nf[d]]    = s;
              f_dat[d][nf[d]]  = tdata_d[d];
              f_last[d][nf[d]] = tlast_d[d];
              nf[d]++;
            end
          end
          el  = 1'b1;
          eb  = 1'b0;
          ep  = 1'b0;
          lvl = 0;
          for (int k = 0; k < nf[d]; k++) begin
            s = f_s[d][k];
            if (s <= e && e < s + len) el = frame_bit(d, f_dat[d][k], (e - s) / dv);
            if (f_a[d][k] < e && s + len > e) eb = 1'b1;
            if (f_last[d][k] && e == s + len - 1) ep = 1'b1;
            if (f_a[d][k] <= e && e < s - 1) lvl++;
          end
          exp_lvl[d] = lvl;
          check($sformatf("d%0d line @%0d", d, e), line_s[d], el);
          check($sformatf("d%0d level @%0d", d, e), lvl_s[d], lvl);
          check($sformatf("d%0d tready @%0d", d, e), tready_s[d], (lvl != cfg_depth(d)));
          check($sformatf("d%0d busy @%0d", d, e), busy_s[d], eb);
          check($sformatf("d%0d pkt_done @%0d", d, e), pkt_s[d], ep);
        end
        if (!(rst_n && tvalid_d[d] && !acc)) begin
          case (mode)
            0:       tvalid_d[d] = ($urandom_range(0, 39) == 0);
            1:       tvalid_d[d] = 1'b1;
            3:       tvalid_d[d] = ($urandom_range(0, 9) == 0);
            default: tvalid_d[d] = 1'b0;
          endcase
          tdata_d[d] = 8'($urandom);
          tlast_d[d] = ($urandom_range(0, 2) == 0);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    mode = 1; repeat (300) @(posedge clk);
    mode = 2; repeat (500) @(posedge clk);
    mode = 0; repeat (800) @(posedge clk);
    mode = 3; repeat (600) @(posedge clk);
    mode = 1; repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d async rst line", d), line_s[d], 1);
      check($sformatf("d%0d async rst level", d), lvl_s[d], 0);
      check($sformatf("d%0d async rst tready", d), tready_s[d], 1);
      check($sformatf("d%0d async rst busy", d), busy_s[d], 0);
    end
    mode = 2;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    mode = 3; repeat (600) @(posedge clk);
    mode = 2; repeat (500) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
Parametrised AXI-Stream-to-UART transmitter. It is the next-generation replacement for the fixed 8N1 byte emitter that follows the score core in board tops. It adds configurable baud, data width, parity and stop bits, a FIFO decoupling buffer, and end-of-packet signalling. It sits between a byte stream producer and the board UART TX pin.

Parameters:
CLK_FREQ, 16000000, i_clk frequency in Hz
BAUD_RATE, 57600, line rate; DIV = CLK_FREQ/BAUD_RATE (truncated), elaboration error if DIV < 2
DATA_BITS, 8, payload bits per frame, 5..8; i_tdata[DATA_BITS-1:0] used, upper bits ignored
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries, power of two >= 2

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active low
i_tdata  in  8  stream byte
i_tlast  in  1  last byte of packet
i_tvalid  in  1  stream valid
o_tready  out  1  stream ready
o_uart_tx  out  1  serial line, idle high
o_busy  out  1  FIFO non-empty or frame in progress
o_pkt_done  out  1  one-cycle pulse at end of a tlast frame
o_fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset state (asynchronous, applied immediately on i_rst_n low): o_uart_tx=1, FIFO empty, o_fifo_level=0, FSM=IDLE, o_busy=0, o_pkt_done=0. o_tready=1 while empty.
- FIFO:
  - Stores {tlast, data[DATA_BITS-1:0]}.
  - o_tready = (o_fifo_level != FIFO_DEPTH), derived from registered level.
  - Push on the i_tvalid & o_tready edge. When full, i_tdata/i_tlast are ignored and must be held by the producer (AXI rule).
  - Push and pop in the same cycle leave the level unchanged. The FIFO never over- or underflows.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP.
  - Every bit lasts exactly DIV clocks, timed by a baud counter reloaded at each bit boundary.
  - IDLE: line high. If FIFO non-empty, pop into the shift register that cycle and go to START. A byte pushed into an empty idle block at edge t gives a start bit on o_uart_tx from edge t+2.
  - START: line 0 for DIV clocks.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: present only if PARITY!=0. Even: XOR of data bits. Odd: inverted XOR.
  - STOP: line 1 for STOP_BITS*DIV clocks.
  - On the last STOP clock: if the FIFO is non-empty, pop and go directly to START, giving zero idle gap between frames. Otherwise go to IDLE.
- o_uart_tx is registered; there are no combinational glitches.
- o_pkt_done is high for exactly the last STOP clock of a frame whose stored tlast=1.
- o_busy = (FSM != IDLE) | (level != 0).
- Reset mid-frame: the line returns high immediately, the partial frame and all FIFO contents are discarded, and no residual bits are sent after release.
- i_tvalid during reset: ignored. The first accept is possible at the first edge after release.

Test Plan:
- 8N1, DIV=4, push 0x55 at edge 0 -> o_uart_tx low from edge 2 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high. Total frame 40 clocks. o_busy drops on the clock after the stop ends.
- DATA_BITS=7, PARITY=2, send 0x41 -> parity bit 0, frame length 10 bits. Same with PARITY=1 -> parity bit 1. Upper bit 7 of i_tdata set is ignored.
- FIFO_DEPTH=4, i_tvalid held high from edge 0 -> exactly 5 bytes accepted (edges 0-4, one popped at edge 1), then o_tready=0, o_fifo_level=4. o_tready reasserts on the first STOP-end pop. All bytes emit in order with no inter-frame gap.
- STOP_BITS=2, two queued bytes -> stop high for 8 clocks (DIV=4), then the second start bit begins on the next clock.
- Packet of 3 bytes, tlast on the third -> o_pkt_done pulses once, on the last stop clock of frame 3 only.
- i_rst_n low during data bit 3 with 2 bytes queued -> o_uart_tx=1 and o_fifo_level=0 immediately. After release the line stays high for at least 2 frame times and o_busy=0.
